// File: rtl/wb_cmd_initiator.sv
// Wishbone B4 pipelined single-beat initiator; command stream in, auto-incrementing address, watchdog abort.
// Latency: bus cycle 1 clk after accept, response 1 clk after ack; backpressure: cmd_ready_o low until the response.
module wb_cmd_initiator #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 17,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic                  cmd_set_addr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  wb_we_o,
    output logic                  wb_cycle_o,
    output logic                  wb_strobe_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  timed_out;

    assign cmd_ready_o = (state == IDLE);
    assign cnt_inc     = cnt + CNT_W'(1);
    // The edge that would bring the count to the limit is the abort edge.
    assign timed_out   = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            cnt         <= '0;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            wb_we_o     <= 1'b0;
            wb_cycle_o  <= 1'b0;
            wb_strobe_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_set_addr_i) begin
                            addr_q    <= cmd_addr_i;
                            wb_addr_o <= cmd_addr_i;
                        end else begin
                            wb_addr_o <= addr_q;
                        end
                        wb_we_o     <= cmd_we_i;
                        wb_data_o   <= cmd_data_i;
                        wb_cycle_o  <= 1'b1;
                        wb_strobe_o <= 1'b1;
                        cnt         <= '0;
                        state       <= REQ;
                    end
                end
                REQ, WAIT_ACK: begin
                    cnt <= cnt_inc;
                    if (state == REQ && !wb_stall_i) begin
                        wb_strobe_o <= 1'b0;
                        state       <= WAIT_ACK;
                    end
                    // Ack takes priority over a timeout landing on the same edge.
                    if (wb_ack_i) begin
                        wb_cycle_o  <= 1'b0;
                        wb_strobe_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        if (!wb_we_o) begin
                            rsp_data_o <= wb_data_i;
                        end
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        state  <= IDLE;
                    end else if (timed_out) begin
                        wb_cycle_o  <= 1'b0;
                        wb_strobe_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_data_o  <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
